// File: rtl/io_uart_bridge.sv
// io_uart_bridge: core byte streams <-> 8N1 UART, with TX/RX FIFOs and RX error pulses.
module io_uart_bridge #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] io_o_data,
   input  logic       io_o_valid,
   output logic       io_o_ready,
   output logic [7:0] io_i_data,
   output logic       io_i_valid,
   input  logic       io_i_ready,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   // Full when the wrap bits differ and the indices match.
   function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
      return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
   endfunction

   // ---------------- TX FIFO ----------------
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, tx_wr_nxt, tx_rd_nxt;
   logic          tx_empty, tx_full, tx_push_c, tx_pop_c;

   assign tx_empty  = (tx_wr_ptr == tx_rd_ptr);
   assign tx_full   = ptr_full(tx_wr_ptr, tx_rd_ptr);
   assign tx_push_c = io_o_valid && !tx_full;
   assign tx_wr_nxt = tx_wr_ptr + PW'(tx_push_c);
   assign tx_rd_nxt = tx_rd_ptr + PW'(tx_pop_c);

   // TX FIFO storage.
   always_ff @(posedge clk) begin
      if (tx_push_c) tx_mem[tx_wr_ptr[AW-1:0]] <= io_o_data;
   end

   // TX pointers and registered ready flag.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx_wr_ptr  <= '0;
         tx_rd_ptr  <= '0;
         io_o_ready <= 1'b1;
      end else begin
         tx_wr_ptr  <= tx_wr_nxt;
         tx_rd_ptr  <= tx_rd_nxt;
         io_o_ready <= !ptr_full(tx_wr_nxt, tx_rd_nxt);
      end
   end

   // ---------------- TX serializer ----------------
   tx_state_t     tx_state, tx_state_nxt;
   logic [CW-1:0] tx_cnt, tx_cnt_nxt;
   logic [2:0]    tx_idx, tx_idx_nxt;
   logic [7:0]    tx_shift, tx_shift_nxt;
   logic          tx_bit_c;

   // TX state register; line level lags state by one cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_idx   <= tx_idx_nxt;
         tx_shift <= tx_shift_nxt;
         uart_tx  <= tx_bit_c;
      end
   end

   // TX next state: each non-idle state lasts CLKS_PER_BIT cycles.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_idx_nxt   = tx_idx;
      tx_shift_nxt = tx_shift;
      tx_pop_c     = 1'b0;
      tx_bit_c     = 1'b1;
      unique case (tx_state)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop_c     = 1'b1;
               tx_shift_nxt = tx_mem[tx_rd_ptr[AW-1:0]];
               tx_cnt_nxt   = CNT_BIT;
               tx_state_nxt = TX_START;
            end
         end
         TX_START: begin
            tx_bit_c = 1'b0;
            if (tx_cnt == '0) begin
               tx_cnt_nxt   = CNT_BIT;
               tx_idx_nxt   = '0;
               tx_state_nxt = TX_DATA;
            end else begin
               tx_cnt_nxt = tx_cnt - CW'(1);
            end
         end
         TX_DATA: begin
            tx_bit_c = tx_shift[0];
            if (tx_cnt == '0) begin
               tx_cnt_nxt   = CNT_BIT;
               tx_shift_nxt = {1'b0, tx_shift[7:1]};
               if (tx_idx == 3'd7) tx_state_nxt = TX_STOP;
               else                tx_idx_nxt   = tx_idx + 3'd1;
            end else begin
               tx_cnt_nxt = tx_cnt - CW'(1);
            end
         end
         TX_STOP: begin
            tx_bit_c = 1'b1;
            if (tx_cnt == '0) tx_state_nxt = TX_IDLE;
            else              tx_cnt_nxt   = tx_cnt - CW'(1);
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // ---------------- RX deserializer ----------------
   logic [1:0]    rx_sync;
   logic          rx_s;
   rx_state_t     rx_state, rx_state_nxt;
   logic [CW-1:0] rx_cnt, rx_cnt_nxt;
   logic [2:0]    rx_idx, rx_idx_nxt;
   logic [7:0]    rx_shift, rx_shift_nxt;
   logic          rx_push_c, frame_err_c, overrun_c;

   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [PW-1:0] rx_wr_ptr, rx_rd_ptr, rx_wr_nxt, rx_rd_nxt;
   logic          rx_empty, rx_full, rx_pop_c;

   assign rx_s = rx_sync[1];

   // Two-flop synchronizer for the asynchronous serial input.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) rx_sync <= 2'b11;
      else       rx_sync <= {rx_sync[0], uart_rx};
   end

   // RX state register and registered error pulses.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_idx       <= '0;
         rx_shift     <= '0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_state     <= rx_state_nxt;
         rx_cnt       <= rx_cnt_nxt;
         rx_idx       <= rx_idx_nxt;
         rx_shift     <= rx_shift_nxt;
         rx_frame_err <= frame_err_c;
         rx_overrun   <= overrun_c;
      end
   end

   // RX next state: mid-bit sampling, stop-bit check, break lockout.
   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_idx_nxt   = rx_idx;
      rx_shift_nxt = rx_shift;
      rx_push_c    = 1'b0;
      frame_err_c  = 1'b0;
      overrun_c    = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_cnt_nxt   = CNT_HALF;
               rx_state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == '0) begin
               if (rx_s) begin
                  rx_state_nxt = RX_IDLE;
               end else begin
                  rx_cnt_nxt   = CNT_BIT;
                  rx_idx_nxt   = '0;
                  rx_state_nxt = RX_DATA;
               end
            end else begin
               rx_cnt_nxt = rx_cnt - CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt == '0) begin
               rx_cnt_nxt   = CNT_BIT;
               rx_shift_nxt = {rx_s, rx_shift[7:1]};
               if (rx_idx == 3'd7) rx_state_nxt = RX_STOP;
               else                rx_idx_nxt   = rx_idx + 3'd1;
            end else begin
               rx_cnt_nxt = rx_cnt - CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt == '0) begin
               if (rx_s) begin
                  if (rx_full) overrun_c = 1'b1;
                  else         rx_push_c = 1'b1;
                  rx_state_nxt = RX_IDLE;
               end else begin
                  frame_err_c  = 1'b1;
                  rx_state_nxt = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_nxt = rx_cnt - CW'(1);
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_s) rx_state_nxt = RX_IDLE;
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // ---------------- RX FIFO (first-word-fall-through) ----------------
   assign rx_empty  = (rx_wr_ptr == rx_rd_ptr);
   assign rx_full   = ptr_full(rx_wr_ptr, rx_rd_ptr);
   assign rx_pop_c  = io_i_ready && !rx_empty;
   assign rx_wr_nxt = rx_wr_ptr + PW'(rx_push_c);
   assign rx_rd_nxt = rx_rd_ptr + PW'(rx_pop_c);
   assign io_i_data = rx_mem[rx_rd_ptr[AW-1:0]];

   // RX FIFO storage.
   always_ff @(posedge clk) begin
      if (rx_push_c) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_shift;
   end

   // RX pointers and registered valid flag.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_wr_ptr  <= '0;
         rx_rd_ptr  <= '0;
         io_i_valid <= 1'b0;
      end else begin
         rx_wr_ptr  <= rx_wr_nxt;
         rx_rd_ptr  <= rx_rd_nxt;
         io_i_valid <= (rx_wr_nxt != rx_rd_nxt);
      end
   end

endmodule

// File: tb/tb_io_uart_bridge.sv
// tb_io_uart_bridge: directed test of io_uart_bridge with CLKS_PER_BIT=8, FIFO_DEPTH=16.
`timescale 1ns/1ps
module tb_io_uart_bridge;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [7:0] io_o_data = 8'h00;
   logic       io_o_valid = 1'b0;
   logic       io_o_ready;
   logic [7:0] io_i_data;
   logic       io_i_valid;
   logic       io_i_ready = 1'b0;
   logic       uart_tx;
   logic       uart_rx = 1'b1;
   logic       rx_frame_err;
   logic       rx_overrun;

   io_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .io_o_data    (io_o_data),
      .io_o_valid   (io_o_valid),
      .io_o_ready   (io_o_ready),
      .io_i_data    (io_i_data),
      .io_i_valid   (io_i_valid),
      .io_i_ready   (io_i_ready),
      .uart_tx      (uart_tx),
      .uart_rx      (uart_rx),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int frame_err_cnt = 0;
   int overrun_cnt   = 0;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Count error pulses (one count per high cycle).
   always @(negedge clk) begin
      if (rx_frame_err === 1'b1) frame_err_cnt++;
      if (rx_overrun === 1'b1)   overrun_cnt++;
   end

   // Reference UART receiver watching uart_tx, mid-bit sampling.
   logic [7:0] tx_q[$];
   bit         m_busy = 1'b0;
   int         m_cnt  = 0;
   logic [7:0] m_sh   = 8'h00;
   always @(negedge clk) begin
      if (!nrst) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (uart_tx === 1'b0) begin
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end else begin
         m_cnt++;
         if (m_cnt >= 12 && m_cnt <= 68 && (m_cnt % 8) == 4) m_sh = {uart_tx, m_sh[7:1]};
         if (m_cnt == 76) begin
            if (uart_tx === 1'b1) tx_q.push_back(m_sh);
            m_busy = 1'b0;
         end
      end
   end

   // Present one byte to the TX side; accepted on the next rising edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      io_o_data  = b;
      io_o_valid = 1'b1;
      @(posedge clk);
      #1 io_o_valid = 1'b0;
   endtask

   // Drive one 8N1 frame on uart_rx, stop bit level selectable.
   task automatic send_rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         uart_rx = fr[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   // Pop the RX head for one cycle.
   task automatic pop_rx();
      io_i_ready = 1'b1;
      @(negedge clk);
      io_i_ready = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [9:0] fr;
      int n, acc_before, low_cnt, lows;
      bit drop_seen, reas, rdy;

      // Reset state
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_ready", io_o_ready, 1);
      check("rst_i_valid", io_i_valid, 0);
      check("rst_frame_err", rx_frame_err, 0);
      check("rst_overrun", rx_overrun, 0);

      // Single byte 0xA5: two idle cycles, then 10 bit periods of 8 cycles
      send_byte(8'hA5);
      @(negedge clk); check("a5_idle0", uart_tx, 1);
      @(negedge clk); check("a5_idle1", uart_tx, 1);
      fr = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         check("a5_line", uart_tx, fr[i/8]);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("a5_after", uart_tx, 1);
      end
      check("a5_mon_cnt", tx_q.size(), 1);
      if (tx_q.size() > 0) check("a5_mon_byte", tx_q[0], 8'hA5);
      repeat (10) @(negedge clk);
      tx_q.delete();

      // Burst of 20 bytes with valid held: 17 accepts, then ready low 66 cycles
      n = 0; acc_before = -1; low_cnt = 0; drop_seen = 0; reas = 0;
      for (int cyc = 0; cyc < 3000 && n < 20; cyc++) begin
         @(negedge clk);
         io_o_data  = 8'(n);
         io_o_valid = 1'b1;
         rdy = io_o_ready;
         if (!rdy) begin
            if (!drop_seen) begin
               drop_seen  = 1;
               acc_before = n;
            end
            if (!reas) low_cnt++;
         end else if (drop_seen) begin
            reas = 1;
         end
         @(posedge clk);
         if (rdy) n++;
      end
      #1 io_o_valid = 1'b0;
      check("burst_accepts", n, 20);
      check("burst_before_full", acc_before, 17);
      check("burst_ready_low", low_cnt, 66);
      for (int cyc = 0; cyc < 3000 && tx_q.size() < 20; cyc++) @(negedge clk);
      check("burst_line_cnt", tx_q.size(), 20);
      for (int i = 0; i < 20 && i < tx_q.size(); i++) check("burst_line_byte", tx_q[i], i);
      repeat (20) @(negedge clk);

      // RX 0x3C, FWFT head, single pop
      send_rx_frame(8'h3C, 1'b1);
      check("rx3c_valid", io_i_valid, 1);
      check("rx3c_data", io_i_data, 8'h3C);
      pop_rx();
      check("rx3c_popped", io_i_valid, 0);

      // Short glitch: no byte, no error
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_valid", io_i_valid, 0);
      check("glitch_ferr", frame_err_cnt, 0);
      check("glitch_ovr", overrun_cnt, 0);

      // Bad stop bit, break held low, then a clean 0x12
      send_rx_frame(8'h55, 1'b0);
      repeat (40) @(negedge clk);
      uart_rx = 1'b1;
      repeat (16) @(negedge clk);
      check("ferr_count", frame_err_cnt, 1);
      check("ferr_no_push", io_i_valid, 0);
      send_rx_frame(8'h12, 1'b1);
      check("post_break_valid", io_i_valid, 1);
      check("post_break_data", io_i_data, 8'h12);
      pop_rx();
      check("post_break_empty", io_i_valid, 0);
      check("post_break_ferr", frame_err_cnt, 1);

      // Overrun: 17 frames into a 16-deep FIFO
      for (int i = 1; i <= 16; i++) send_rx_frame(8'(i), 1'b1);
      check("ovr_none_yet", overrun_cnt, 0);
      send_rx_frame(8'h11, 1'b1);
      repeat (4) @(negedge clk);
      check("ovr_count", overrun_cnt, 1);
      for (int i = 1; i <= 16; i++) begin
         check("drain_valid", io_i_valid, 1);
         check("drain_data", io_i_data, i);
         pop_rx();
      end
      check("drain_empty", io_i_valid, 0);
      check("ovr_ferr_unchanged", frame_err_cnt, 1);

      // Reset mid-TX-frame with an RX byte and a queued TX byte pending
      send_rx_frame(8'h77, 1'b1);
      check("pre_rst_rx_valid", io_i_valid, 1);
      tx_q.delete();
      send_byte(8'h0F);
      send_byte(8'hF0);
      repeat (4) @(negedge clk);
      check("pre_rst_start_bit", uart_tx, 0);
      nrst = 1'b0;
      #1;
      check("rst_mid_uart_tx", uart_tx, 1);
      check("rst_mid_i_valid", io_i_valid, 0);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("rst_rel_ready", io_o_ready, 1);
      check("rst_rel_i_valid", io_i_valid, 0);
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      check("rst_no_tx_lows", lows, 0);
      check("rst_no_tx_bytes", tx_q.size(), 0);
      check("rst_rx_still_empty", io_i_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
